// File: rtl/i2s_pkg.sv
// Shared constants and encodings for the I2S slave endpoint.
// Default sizes live here so that the bench and the RTL agree on them.
package i2s_pkg;

  localparam int SLOT_BITS_DEF = 32;
  localparam int RX_BITS_DEF   = 24;
  localparam int TX_BITS_DEF   = 16;
  localparam int OK_FRAMES_DEF = 4;
  localparam int TIMEOUT_DEF   = 1024;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The LRCLK level selects the channel directly.
  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser for one asynchronous input.
// With EDGES set, a history flop adds one-clk rise/fall strobes.
module i2s_edge_sync #(
  parameter bit EDGES = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      stable <= 1'b0;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign level = stable;

  generate
    if (EDGES) begin : g_edges
      logic hist;

      always_ff @(posedge clk) begin
        if (reset) hist <= 1'b0;
        else       hist <= stable;
      end

      assign rise = stable & ~hist;
      assign fall = ~stable & hist;
    end else begin : g_level
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_slave_port.sv
// I2S slave: oversamples BCLK/LRCLK/DIN on clk, captures 24-bit left/right words,
// drives 16-bit words on DOUT and tracks link health.
module i2s_slave_port
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int RX_BITS   = RX_BITS_DEF,
  parameter int TX_BITS   = TX_BITS_DEF,
  parameter int OK_FRAMES = OK_FRAMES_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BCLK,
  input  logic               LRCLK,
  input  logic               DIN,
  output logic               DOUT,
  output logic [RX_BITS-1:0] rx_real,
  output logic [RX_BITS-1:0] rx_imag,
  output logic               rx_valid,
  input  logic [TX_BITS-1:0] tx_real,
  input  logic [TX_BITS-1:0] tx_imag,
  output logic               tx_ready,
  output logic               slot_err,
  output logic               i2s_ok
);

  localparam int CW  = $clog2(SLOT_BITS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int GW  = $clog2(OK_FRAMES + 1);
  localparam int TXW = $clog2(TX_BITS);

  logic       bclk_rise, bclk_fall, lr_lvl, din_lvl;
  logic       bclk_level_unused;
  logic [1:0] lr_edges_unused, din_edges_unused;

  i2s_edge_sync #(.EDGES(1'b1)) u_bclk (
    .clk(clk), .reset(reset), .d(BCLK),
    .level(bclk_level_unused), .rise(bclk_rise), .fall(bclk_fall)
  );
  i2s_edge_sync #(.EDGES(1'b0)) u_lrclk (
    .clk(clk), .reset(reset), .d(LRCLK),
    .level(lr_lvl), .rise(lr_edges_unused[0]), .fall(lr_edges_unused[1])
  );
  i2s_edge_sync #(.EDGES(1'b0)) u_din (
    .clk(clk), .reset(reset), .d(DIN),
    .level(din_lvl), .rise(din_edges_unused[0]), .fall(din_edges_unused[1])
  );

  state_t             state;
  logic               lr_prev;
  logic [CW-1:0]      bit_cnt;      // index of the latest bclk_rise in this slot
  logic [RX_BITS-2:0] shift_reg;
  logic [RX_BITS-1:0] hold_real;
  logic [TX_BITS-1:0] shadow_real, shadow_imag;
  logic [GW-1:0]      good_cnt;
  logic [TW-1:0]      idle_cnt;

  logic               lr_change, left_start, slot_ok, timeout, tx_bit;
  logic [CW-1:0]      next_idx;
  logic [RX_BITS-1:0] word;
  logic [TXW-1:0]     tx_sel;
  channel_t           chan;

  assign chan       = channel_t'(lr_prev);
  assign lr_change  = bclk_rise && (lr_lvl != lr_prev);
  assign left_start = lr_change && (lr_lvl == LEFT);
  assign slot_ok    = (bit_cnt == CW'(SLOT_BITS - 1));
  assign next_idx   = (bit_cnt == CW'(SLOT_BITS)) ? bit_cnt : bit_cnt + 1'b1;
  assign word       = {shift_reg, din_lvl};
  assign timeout    = (state == RUN) && !bclk_rise && (idle_cnt == TW'(TIMEOUT - 1));
  assign tx_sel     = TXW'(TX_BITS - 1) - bit_cnt[TXW-1:0];
  assign tx_bit     = (chan == LEFT) ? shadow_real[tx_sel] : shadow_imag[tx_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      lr_prev     <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      hold_real   <= '0;
      shadow_real <= '0;
      shadow_imag <= '0;
      good_cnt    <= '0;
      idle_cnt    <= '0;
      DOUT        <= 1'b0;
      rx_real     <= '0;
      rx_imag     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      slot_err    <= 1'b0;
      i2s_ok      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      slot_err <= 1'b0;

      if (bclk_rise) lr_prev <= lr_lvl;

      if (bclk_rise || state == HUNT) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + 1'b1;

      if (left_start) begin
        shadow_real <= tx_real;
        shadow_imag <= tx_imag;
        tx_ready    <= 1'b1;
      end

      // DOUT moves on the falling edge so the master sees it settled at its rise.
      if (bclk_fall)
        DOUT <= (state == RUN) && (bit_cnt < CW'(TX_BITS)) && tx_bit;

      case (state)
        HUNT: begin
          if (left_start) begin
            state   <= RUN;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          if (timeout) begin
            state    <= HUNT;
            good_cnt <= '0;
            i2s_ok   <= 1'b0;
            DOUT     <= 1'b0;
          end else if (lr_change) begin
            if (!slot_ok) begin
              slot_err <= 1'b1;
              state    <= HUNT;
              good_cnt <= '0;
              i2s_ok   <= 1'b0;
              DOUT     <= 1'b0;
            end else begin
              bit_cnt <= '0;
              if (left_start) begin
                if (good_cnt != GW'(OK_FRAMES)) good_cnt <= good_cnt + 1'b1;
                i2s_ok <= (good_cnt >= GW'(OK_FRAMES - 1));
              end
            end
          end else if (bclk_rise) begin
            bit_cnt <= next_idx;
            if (next_idx <= CW'(RX_BITS)) shift_reg <= word[RX_BITS-2:0];
            if (next_idx == CW'(RX_BITS)) begin
              if (chan == LEFT) begin
                hold_real <= word;
              end else begin
                rx_real  <= hold_real;
                rx_imag  <= word;
                rx_valid <= 1'b1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule
